// File: rtl/mux_rr_nto1_reg.sv
// mux_rr_nto1_reg
//   N-channel, W-bit valid/ready multiplexer feeding a one-entry registered
//   output stage. The channel select is derived internally, either by fixed
//   priority (lowest index wins) or by a round-robin pointer that advances
//   only on accepted transfers.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_data    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word present
//   in_ready   per-channel accept strobe (one-hot or zero)
//   out_data   registered selected word
//   out_chan   source channel of out_data
//   out_valid  out_data holds a word
//   out_ready  consumer takes the word this cycle
module mux_rr_nto1_reg #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter bit RR_MODE  = 1'b1,
  localparam int CW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    chan_q,  chan_d;
  logic [CW-1:0]    ptr_q,   ptr_d;

  logic             load;
  logic             gnt_vld;
  logic [CW-1:0]    gnt_idx;
  logic [WIDTH-1:0] gnt_word;
  logic             xfer;
  int               scan;

  // Arbiter: visit channels starting at the pointer (or at 0 in fixed
  // priority mode) and take the first valid one. The inner loop keeps every
  // vector index a loop constant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan = RR_MODE ? ((int'(ptr_q) + k) % CHANNELS) : k;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!gnt_vld && (c == scan) && in_valid[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = CW'(c);
        end
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt_idx == CW'(c)) gnt_word = in_data[c*WIDTH +: WIDTH];
    end
  end

  // FULL implies out_valid, so a consume is just out_ready while FULL.
  assign load = (state_q == EMPTY) || out_ready;
  assign xfer = rst_n && load && gnt_vld;

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (xfer && (gnt_idx == CW'(c))) in_ready[c] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      // Covers both a load into EMPTY and a zero-bubble reload while FULL.
      state_d = FULL;
      data_d  = gnt_word;
      chan_d  = gnt_idx;
      if (RR_MODE) ptr_d = (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_rr_nto1_reg.sv
// Bench for mux_rr_nto1_reg: one round-robin and one fixed-priority instance
// share the same stimulus. A per-instance behavioural model (held word,
// channel, pointer) is compared every cycle; directed checks pin key values.
module tb_mux_rr_nto1_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0] ir_rr, ir_fp;
  logic [4:0] od_rr, od_fp;
  logic [1:0] oc_rr, oc_fp;
  logic       ov_rr, ov_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_nto1_reg #(.WIDTH(5), .CHANNELS(4), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_rr), .out_data(od_rr), .out_chan(oc_rr),
    .out_valid(ov_rr), .out_ready(out_ready));

  mux_rr_nto1_reg #(.WIDTH(5), .CHANNELS(4), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir_fp), .out_data(od_fp), .out_chan(oc_fp),
    .out_valid(ov_fp), .out_ready(out_ready));

  // ---------------- behavioural model (index 0 = fixed, 1 = round-robin)
  bit         m_known = 1'b0;
  bit         m_full [2];
  logic [4:0] m_data [2];
  int         m_chan [2];
  int         m_ptr  [2];

  function automatic int pick(input bit rr, input int ptr, input logic [3:0] v);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = rr ? (ptr + k) % 4 : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_cmp(input int m, input logic ov, input logic [4:0] od,
                           input logic [1:0] oc, input logic [3:0] ir);
    int g;
    logic [3:0] exp_ir;
    g = pick(m == 1, m_ptr[m], in_valid);
    exp_ir = '0;
    if (rst_n && (!m_full[m] || out_ready) && g >= 0) exp_ir[g] = 1'b1;
    chk(m ? "rr.model.out_valid" : "fp.model.out_valid", int'(ov), int'(m_full[m]));
    if (m_full[m]) begin
      chk(m ? "rr.model.out_data" : "fp.model.out_data", int'(od), int'(m_data[m]));
      chk(m ? "rr.model.out_chan" : "fp.model.out_chan", int'(oc), m_chan[m]);
    end
    chk(m ? "rr.model.in_ready" : "fp.model.in_ready", int'(ir), int'(exp_ir));
    // advance to the state seen after the coming clock edge
    if (!rst_n) begin
      m_full[m] = 1'b0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
    end else if (exp_ir != 0) begin
      m_full[m] = 1'b1;
      m_data[m] = in_data[g*5 +: 5];
      m_chan[m] = g;
      if (m == 1) m_ptr[m] = (g + 1) % 4;
    end else if (m_full[m] && out_ready) begin
      m_full[m] = 1'b0;
    end
  endtask

  // inputs change only just after posedge, so negedge sees stable inputs
  always @(negedge clk) begin
    if (m_known) begin
      model_cmp(0, ov_fp, od_fp, oc_fp, ir_fp);
      model_cmp(1, ov_rr, od_rr, oc_rr, ir_rr);
    end else if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_full[m] = 1'b0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
      end
      m_known = 1'b1;
    end
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] tv_valid [8] = '{4'b0011, 4'b0011, 4'b1000, 4'b0000, 4'b0110, 4'b1111, 4'b0101, 4'b0000};
  logic       tv_ready [8] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1};

  initial begin
    // ch3=03 ch2=1A ch1=11 ch0=07
    in_data   = {5'h03, 5'h1A, 5'h11, 5'h07};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;

    // T1 reset with all channels requesting
    tick(); tick();
    chk("t1.out_valid", int'(ov_rr), 0);
    chk("t1.out_data",  int'(od_rr), 0);
    chk("t1.out_chan",  int'(oc_rr), 0);
    chk("t1.in_ready",  int'(ir_rr), 0);
    chk("t1.fp.in_ready", int'(ir_fp), 0);

    // T2 single channel 2
    rst_n = 1'b1; in_valid = 4'b0100;
    #1 chk("t2.in_ready", int'(ir_rr), 4'b0100);
    tick();
    chk("t2.out_data",  int'(od_rr), 5'h1A);
    chk("t2.out_chan",  int'(oc_rr), 2);
    chk("t2.out_valid", int'(ov_rr), 1);

    // T3 round-robin from pointer 0, no gaps
    in_valid = 4'b1111;
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3.out_valid", int'(ov_rr), 1);
      chk("t3.out_chan",  int'(oc_rr), i % 4);
      chk("t3.fp.out_chan", int'(oc_fp), 0);
    end

    // T4 backpressure: holding ch0 word, pointer now 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4.in_ready", int'(ir_rr), 0);
      tick();
      chk("t4.out_data", int'(od_rr), 5'h07);
      chk("t4.out_chan", int'(oc_rr), 0);
    end
    out_ready = 1'b1;
    #1 chk("t4.release.in_ready", int'(ir_rr), 4'b0010);
    tick();
    chk("t4.release.out_chan", int'(oc_rr), 1);
    chk("t4.release.out_data", int'(od_rr), 5'h11);

    // T5 fixed priority with channels 1 and 3 requesting
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5.in_ready", int'(ir_fp), 4'b0010);
      tick();
      chk("t5.out_chan", int'(oc_fp), 1);
    end

    // T6 reset while FULL with pointer 2
    do_reset(1);
    in_valid = 4'b0010;
    tick();
    chk("t6.pre.out_chan", int'(oc_rr), 1);
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
    #1 chk("t6.in_ready_in_reset", int'(ir_rr), 0);
    tick();
    chk("t6.out_valid", int'(ov_rr), 0);
    rst_n = 1'b1;
    #1 chk("t6.first_grant", int'(ir_rr), 4'b0001);
    tick();
    chk("t6.out_chan", int'(oc_rr), 0);

    // mixed valid / ready patterns, checked by the model alone
    for (int i = 0; i < 8; i++) begin
      in_valid  = tv_valid[i];
      out_ready = tv_ready[i];
      in_data   = {5'(i + 3), 5'(i * 3), 5'(i + 17), 5'(i * 5)};
      tick();
    end
    out_ready = 1'b1; in_valid = 4'b0000;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
